// File: rtl/frame_streamer.sv
// frame_streamer: once the filter pass finishes, reads the 64x64 output image
// in raster order and streams it out as tagged valid/ready beats. A small
// prefetch FIFO, filled only as far as the credit allows, hides the memory
// read latency so a sink that is always ready sees one pixel per cycle.
//
//   state  | meaning
//   IDLE   | waiting for a rising edge on filter_done
//   STREAM | issuing read addresses in raster order
//   FLUSH  | every address issued, draining until the last beat is accepted
module frame_streamer #(
  parameter int RD_LAT     = 1,
  parameter bit GREEN_ONLY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        filter_done,
  output logic [5:0]  row,
  output logic [5:0]  col,
  input  logic [23:0] rd_pix,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [23:0] m_data,
  output logic [5:0]  m_row,
  output logic [5:0]  m_col,
  output logic        m_last,
  output logic        busy,
  output logic        frame_done
);

  localparam int          DEPTH = RD_LAT + 2;
  localparam logic [12:0] NPIX  = 13'd4096;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t      state_q;
  logic        fd_q;
  logic [12:0] issue_q;
  logic [5:0]  row_q, col_q;
  logic        busy_q, done_q;

  // Storage is sized for the largest depth; pointers wrap at DEPTH.
  logic [23:0] fdata_q [4];
  logic [12:0] ftag_q  [4];   // {row, col, last}
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  fifo_cnt_q, fifo_cnt_d;

  logic        start, issue, pop, push;
  logic [11:0] push_tag;
  logic [1:0]  inflight;
  logic [3:0]  occ;
  logic [23:0] pix_in;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign start = filter_done & ~fd_q;
  assign pop   = m_valid & m_ready;

  // Credit check: everything already owned (queued or in flight), minus the
  // beat leaving this cycle, must leave room for one more read.
  always_comb begin
    occ   = 4'(fifo_cnt_q) + 4'(inflight) - 4'(pop);
    issue = (state_q == STREAM) && (issue_q < NPIX) && (occ < 4'(DEPTH));
  end

  if (RD_LAT == 0) begin : g_comb
    assign push     = issue;
    assign push_tag = {row_q, col_q};
    assign inflight = 2'd0;
  end else begin : g_pipe
    logic [RD_LAT-1:0] pv_q;
    logic [11:0]       ptag_q [RD_LAT];

    // Carry each issued address tag until its data appears on rd_pix
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pv_q <= '0;
        for (int i = 0; i < RD_LAT; i++) ptag_q[i] <= '0;
      end else begin
        pv_q[0]   <= issue;
        ptag_q[0] <= {row_q, col_q};
        for (int i = 1; i < RD_LAT; i++) begin
          pv_q[i]   <= pv_q[i-1];
          ptag_q[i] <= ptag_q[i-1];
        end
      end
    end

    assign push     = pv_q[RD_LAT-1];
    assign push_tag = ptag_q[RD_LAT-1];

    // Count reads whose data has not reached the FIFO yet
    always_comb begin
      inflight = 2'd0;
      for (int i = 0; i < RD_LAT; i++) inflight = inflight + 2'(pv_q[i]);
    end
  end

  assign pix_in     = GREEN_ONLY ? {8'h00, rd_pix[15:8], 8'h00} : rd_pix;
  assign fifo_cnt_d = fifo_cnt_q + 3'(push) - 3'(pop);

  // Sequencer: start detection, raster address generation, completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fd_q    <= 1'b0;
      issue_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fd_q   <= filter_done;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= STREAM;
            busy_q  <= 1'b1;
            issue_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        STREAM: begin
          if (issue) begin
            issue_q <= issue_q + 13'd1;
            col_q   <= col_q + 6'd1;
            if (col_q == 6'd63) row_q <= row_q + 6'd1;
            if (issue_q == NPIX - 13'd1) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (pop && m_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Prefetch FIFO; storage is cleared on reset so outputs read as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        fdata_q[i] <= '0;
        ftag_q[i]  <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fdata_q[wr_ptr_q] <= pix_in;
        ftag_q[wr_ptr_q]  <= {push_tag, (push_tag == 12'hFFF)};
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  assign m_valid                = (fifo_cnt_q != 3'd0);
  assign m_data                 = fdata_q[rd_ptr_q];
  assign {m_row, m_col, m_last} = ftag_q[rd_ptr_q];
  assign row                    = row_q;
  assign col                    = col_q;
  assign busy                   = busy_q;
  assign frame_done             = done_q;

endmodule

// File: tb/tb_frame_streamer.sv
// Bench for frame_streamer: four instances (RD_LAT 0/1/2, and GREEN_ONLY with
// RD_LAT 1), each with a latency-matched image memory model. Frames are run
// from a table of scenarios; a raster scoreboard checks every beat.
module tb_frame_streamer;

  logic clk;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   act    = -1;

  logic       fd [4], rdy [4], rst_s [4];
  logic       mv [4], ml [4], bz [4], fdn [4];
  logic [5:0] row_s [4], col_s [4], mr [4], mc [4];
  logic [23:0] md [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] mem_pix(input int k, input logic [5:0] r, input logic [5:0] c);
    if (k == 3 && r == 6'd5 && c == 6'd7) return 24'hA53C7E;
    return {2'b00, r, 2'b00, c, 2'b00, r ^ c};
  endfunction

  function automatic logic [23:0] exp_data(input int k, input logic [5:0] r, input logic [5:0] c);
    logic [23:0] p;
    p = mem_pix(k, r, c);
    if (k == 3) return {8'h00, p[15:8], 8'h00};
    return p;
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int L = (k == 3) ? 1 : k;
    logic [5:0]  a1r, a1c, a2r, a2c;
    logic [23:0] rd;

    always @(posedge clk) begin
      a1r <= row_s[k]; a1c <= col_s[k];
      a2r <= a1r;      a2c <= a1c;
    end
    assign rd = (L == 0) ? mem_pix(k, row_s[k], col_s[k]) :
                (L == 1) ? mem_pix(k, a1r, a1c) : mem_pix(k, a2r, a2c);

    frame_streamer #(.RD_LAT(L), .GREEN_ONLY(k == 3)) u_dut (
      .clk(clk), .rst(rst_s[k]), .filter_done(fd[k]),
      .row(row_s[k]), .col(col_s[k]), .rd_pix(rd),
      .m_valid(mv[k]), .m_ready(rdy[k]), .m_data(md[k]),
      .m_row(mr[k]), .m_col(mc[k]), .m_last(ml[k]),
      .busy(bz[k]), .frame_done(fdn[k])
    );

    always @(negedge clk) begin
      if (act == k) begin
        n_chk++;
        if (u_dut.fifo_cnt_q > 3'(L + 2)) begin
          n_fail++;
          $display("FAIL fifo_depth inst%0d: got %0d limit %0d", k, u_dut.fifo_cnt_q, L + 2);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    int inst; bit rnd; int exp_first; int exp_done;
    int hold; int extra_beat; int rst_beat;
  } vec_t;

  task automatic run_frame(input vec_t v);
    int k, beats, dones, first_t, done_t, ex_t;
    bit stall, ex_done, aborted, seen;
    logic [23:0] hd; logic [5:0] hr, hc, er, ec; logic hl;
    k = v.inst; act = k;
    beats = 0; dones = 0; first_t = -1; done_t = -1; ex_t = -1;
    stall = 0; ex_done = 0; aborted = 0;
    hd = '0; hr = '0; hc = '0; hl = 1'b0;
    fd[k] = 1'b1;
    for (int t = 0; t < 20000; t++) begin
      @(negedge clk);
      if (t == 1 && v.hold == 0) fd[k] = 1'b0;
      if (v.hold > 0 && t == v.hold) fd[k] = 1'b0;
      if (ex_t >= 0 && t == ex_t + 1) fd[k] = 1'b0;
      if (t == 0) chk("busy_after_start", 64'(bz[k]), 64'd1);
      if (mv[k] && first_t < 0) first_t = t;
      if (stall) chk("held_on_stall", {mv[k], md[k], mr[k], mc[k], ml[k]}, {1'b1, hd, hr, hc, hl});
      if (fdn[k]) begin
        dones++;
        if (done_t < 0) begin
          done_t = t;
          chk("busy_at_done", 64'(bz[k]), 64'd0);
        end
      end
      if (v.extra_beat >= 0 && beats == v.extra_beat && !ex_done) begin
        fd[k] = 1'b1; ex_done = 1; ex_t = t;
      end
      rdy[k] = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mv[k] && rdy[k]) begin
        er = 6'(beats / 64); ec = 6'(beats % 64);
        chk($sformatf("beat%0d", beats), {mr[k], mc[k], md[k], ml[k]},
            {er, ec, exp_data(k, er, ec), (beats == 4095)});
        beats++;
        if (v.rst_beat >= 0 && beats == v.rst_beat) begin
          @(posedge clk); #2;
          rst_s[k] = 1'b1; #1;
          chk("async_reset_outputs",
              {mv[k], md[k], mr[k], mc[k], ml[k], row_s[k], col_s[k], bz[k], fdn[k]}, 64'd0);
          @(negedge clk);
          rst_s[k] = 1'b0;
          seen = 0;
          for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            if (mv[k] || bz[k] || fdn[k]) seen = 1;
          end
          chk("quiet_after_reset", 64'(seen), 64'd0);
          aborted = 1;
          break;
        end
      end
      stall = mv[k] && !rdy[k];
      hd = md[k]; hr = mr[k]; hc = mc[k]; hl = ml[k];
      if (done_t >= 0 && t >= done_t + 20 && t >= v.hold + 5) break;
    end
    if (!aborted) begin
      chk($sformatf("beat_count inst%0d", k), 64'(beats), 64'd4096);
      chk($sformatf("done_pulses inst%0d", k), 64'(dones), 64'd1);
      if (v.exp_first >= 0) chk("first_valid_time", 64'(first_t), 64'(v.exp_first));
      if (v.exp_done >= 0) chk("frame_done_time", 64'(done_t), 64'(v.exp_done));
    end
    rdy[k] = 1'b1;
    act = -1;
  endtask

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{1, 0, 2, 4098, 0, -1, -1};
    vecs[1]  = '{0, 0, 1, 4097, 0, -1, -1};
    vecs[2]  = '{2, 0, 3, 4099, 0, -1, -1};
    vecs[3]  = '{0, 1, -1, -1, 0, -1, -1};
    vecs[4]  = '{1, 1, -1, -1, 0, -1, -1};
    vecs[5]  = '{2, 1, -1, -1, 0, -1, -1};
    vecs[6]  = '{3, 0, 2, 4098, 0, -1, -1};
    vecs[7]  = '{1, 0, 2, 4098, 10000, -1, -1};
    vecs[8]  = '{1, 0, 2, 4098, 0, -1, -1};
    vecs[9]  = '{1, 0, 2, 4098, 0, 1000, -1};
    vecs[10] = '{1, 0, -1, -1, 0, -1, 2000};
    vecs[11] = '{1, 0, 2, 4098, 0, -1, -1};

    for (int k = 0; k < 4; k++) begin
      fd[k] = 1'b0; rdy[k] = 1'b1; rst_s[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("reset_state inst%0d", k),
          {mv[k], md[k], mr[k], mc[k], ml[k], row_s[k], col_s[k], bz[k], fdn[k]}, 64'd0);
    for (int k = 0; k < 4; k++) rst_s[k] = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_frame(vecs[i]);
      repeat (4) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_streamer.md
Name: frame_streamer

Overview:
- Downstream stage of the image-processing FSM. Once the filter pass signals completion, this block reads the finished 64x64 output image from the output image memory in raster order.
- It emits the pixels as a valid/ready stream with row/column tags and an end-of-frame marker, for example to a UART/DMA dumper or a checker.
- A small credit-controlled prefetch FIFO hides memory read latency, so the stream sustains one pixel per cycle when the sink is always ready.

Parameters:
- RD_LAT, 1, read latency of the output image memory in cycles; legal values 0..2. 0 means combinational read.
- GREEN_ONLY, 0, if 1 then m_data = {8'h00, rd_pix[15:8], 8'h00}; if 0 the full 24-bit pixel is passed through.

Ports:
- clk  in  1  clock, all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- filter_done  in  1  done flag from the processing FSM; a rising edge starts a frame.
- row  out  6  read row address to the output image memory.
- col  out  6  read column address to the output image memory.
- rd_pix  in  24  pixel read from memory (R 23:16, G 15:8, B 7:0).
- m_valid  out  1  stream data valid.
- m_ready  in  1  sink ready.
- m_data  out  24  pixel value.
- m_row  out  6  row tag of m_data.
- m_col  out  6  column tag of m_data.
- m_last  out  1  high with pixel (63,63).
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last pixel's handshake.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - row=0, col=0, m_valid=0, m_data=0, m_row=0, m_col=0, m_last=0, busy=0, frame_done=0.
  - FIFO emptied, in-flight reads discarded, state=IDLE.
  - The filter_done edge detector register resets to 0. If filter_done is already 1 when reset deasserts, it counts as a rising edge on the first clock.
- States: IDLE, STREAM, FLUSH.
  - IDLE: on the edge where filter_done=1 and its previous registered value=0 -> STREAM, busy=1, issue counter=0. Start edges are ignored in STREAM and FLUSH. A level-held filter_done never retriggers.
  - STREAM: issue reads while issue counter < 4096.
  - FLUSH: entered once the 4096th address has been issued; wait until the FIFO is empty and nothing is in flight.
- Read issue:
  - row/col are registered and hold the address being issued; raster order, col increments first, then row.
  - An address is issued in a cycle only if (fifo_count + inflight + popped_this_cycle_adjust) < FIFO depth.
  - FIFO depth = RD_LAT+2; inflight is at most RD_LAT+1.
  - When no read is issued, row/col hold their value.
- Capture: the data for an address issued in cycle k is sampled from rd_pix at the edge ending cycle k+RD_LAT. It is pushed together with its row/col tag and last flag (tag == 63,63).
- Output:
  - m_valid = FIFO non-empty; m_data, m_row, m_col and m_last show the FIFO head.
  - Pop on m_valid & m_ready. While m_valid=1 and m_ready=0, m_data, m_row, m_col and m_last are held stable.
  - Push and pop in the same cycle is legal; count is unchanged.
  - Overflow is impossible by the credit rule; the bench asserts it never happens.
- Completion: the handshake with m_last=1 causes the next cycle to have frame_done=1, busy=0 and state IDLE. A new start edge in that same frame_done cycle is accepted.
- Timing with m_ready held at 1:
  - First m_valid is at the edge 1+RD_LAT after the start edge, then back-to-back for 4096 cycles.
  - frame_done occurs 4097+RD_LAT cycles after the start edge.
- Pixels must never be dropped, duplicated or reordered under any m_ready pattern.

Test Plan:
- Memory preloaded with pix[r][c] = {2'b0,r, 2'b0,c, r^c}; RD_LAT=1; m_ready=1; pulse filter_done -> 4096 beats in raster order with m_data==pix[m_row][m_col]; m_last only on beat 4096 (63,63); frame_done a single pulse at start+4098.
- Random m_ready (50%), RD_LAT in {0,1,2} -> identical beat sequence to the previous test; m_data stable whenever valid&!ready; FIFO never exceeds RD_LAT+2.
- filter_done held high for 10000 cycles after the rising edge -> exactly one frame, one frame_done; a second 0->1 edge after completion -> a second full frame.
- Extra filter_done edge at beat 1000 while busy -> ignored; the frame completes normally with 4096 beats.
- rst asserted at beat 2000 for 1 cycle (asynchronous, mid-cycle) -> all outputs 0 immediately; no further beats; the next start edge begins again at (0,0).
- GREEN_ONLY=1 with pix=24'hA5_3C_7E -> m_data=24'h00_3C_00 for that beat.
